// File: rtl/vga_pattern_sequencer_if.sv
// Key/vsync inputs and pattern-select outputs of the VGA pattern sequencer.
// The sequencer uses the slave modport; the key and sync driver uses master.
interface vga_pattern_sequencer_if;
  logic       vsync_i;
  logic       btn_next_n_i;
  logic       btn_mode_n_i;
  logic [1:0] pat_type_o;
  logic       auto_mode_o;
  logic       frame_tick_o;
  logic       type_changed_o;

  modport slave (
    input  vsync_i, btn_next_n_i, btn_mode_n_i,
    output pat_type_o, auto_mode_o, frame_tick_o, type_changed_o
  );

  modport master (
    output vsync_i, btn_next_n_i, btn_mode_n_i,
    input  pat_type_o, auto_mode_o, frame_tick_o, type_changed_o
  );
endinterface

// File: rtl/vga_pattern_sequencer.sv
// Steps the VGA pattern select from debounced keys, manually or per AUTO_FRAMES,
// committing changes only at frame start. Optional macro SEQ_SKIP_BLACK_EN skips black in auto mode.
module vga_pattern_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned AUTO_FRAMES     = 72,
  parameter int unsigned DB_W            = 19,
  parameter int unsigned FR_W            = 7
) (
  input logic                    clk,
  input logic                    rst,
  vga_pattern_sequencer_if.slave bus
);

  localparam int unsigned NUM_BTN = 2;

  typedef enum logic [1:0] {S_MAN, S_MAN_PEND, S_AUTO, S_AUTO_PEND} state_e;

  logic [NUM_BTN-1:0] raw_n;
  logic [NUM_BTN-1:0] press;
  logic               next_press, mode_press;

  // lane 0 = next key, lane 1 = mode key
  assign raw_n      = {bus.btn_mode_n_i, bus.btn_next_n_i};
  assign next_press = press[0];
  assign mode_press = press[1];

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    logic            s1_q, s2_q;
    logic            stab_q, stab_d;
    logic            press_q, press_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    always_comb begin
      stab_d  = stab_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      if (s2_q == stab_q) begin
        cnt_d = '0;
      end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        stab_d  = s2_q;
        cnt_d   = '0;
        press_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1_q    <= 1'b1;
        s2_q    <= 1'b1;
        stab_q  <= 1'b1;
        press_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        s1_q    <= raw_n[g];
        s2_q    <= s1_q;
        stab_q  <= stab_d;
        press_q <= press_d;
        cnt_q   <= cnt_d;
      end
    end

    assign press[g] = press_q;
  end

  logic            vsync_d_q;
  logic            fs;
  state_e          state_q, state_d;
  logic [FR_W-1:0] fcnt_q, fcnt_d;
  logic [1:0]      type_q, type_d, type_nxt;
  logic            tick_q, chg_q;
  logic            adv;
  logic            auto_grp;

  assign fs       = vsync_d_q & ~bus.vsync_i;
  assign auto_grp = (state_q == S_AUTO) || (state_q == S_AUTO_PEND);

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    adv     = 1'b0;
    // a mode toggle swallows any advance and pending request in its cycle
    if (mode_press) begin
      state_d = auto_grp ? S_MAN : S_AUTO;
      fcnt_d  = '0;
    end else begin
      case (state_q)
        S_MAN: begin
          if (next_press) begin
            if (fs) adv = 1'b1;
            else    state_d = S_MAN_PEND;
          end
        end
        S_MAN_PEND: begin
          if (fs) begin
            adv     = 1'b1;
            state_d = S_MAN;
          end
        end
        S_AUTO: begin
          if (fs && (next_press || fcnt_q == FR_W'(AUTO_FRAMES - 1))) begin
            adv    = 1'b1;
            fcnt_d = '0;
          end else begin
            if (fs)         fcnt_d  = fcnt_q + FR_W'(1);
            if (next_press) state_d = S_AUTO_PEND;
          end
        end
        S_AUTO_PEND: begin
          if (fs) begin
            adv     = 1'b1;
            fcnt_d  = '0;
            state_d = S_AUTO;
          end
        end
        default: state_d = S_MAN;
      endcase
    end
  end

  always_comb begin
`ifdef SEQ_SKIP_BLACK_EN
    type_nxt = (auto_grp && type_q == 2'b11) ? 2'b01 : type_q + 2'b01;
`else
    type_nxt = type_q + 2'b01;
`endif
    type_d = adv ? type_nxt : type_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_d_q <= 1'b1;
      state_q   <= S_MAN;
      fcnt_q    <= '0;
      type_q    <= 2'b00;
      tick_q    <= 1'b0;
      chg_q     <= 1'b0;
    end else begin
      vsync_d_q <= bus.vsync_i;
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      type_q    <= type_d;
      tick_q    <= fs;
      chg_q     <= adv;
    end
  end

  assign bus.pat_type_o     = type_q;
  assign bus.auto_mode_o    = auto_grp;
  assign bus.frame_tick_o   = tick_q;
  assign bus.type_changed_o = chg_q;

endmodule

// File: doc/vga_pattern_sequencer.md
Name: vga_pattern_sequencer

Overview:
Controller that drives the 2-bit pattern select (type) of the VGA pattern datapath from the board's pushbuttons. It supports manual stepping and automatic cycling, and applies every change only at a frame boundary, detected from the sync generator's vsync, so that no frame tears. It sits between the board key inputs and the VGA top-level type input, in the same 50 MHz pixel-clock domain as the sync generator.

Parameters:
DEBOUNCE_CYCLES, 500000, cycles a synchronized button level must hold stable before it is accepted (10 ms at 50 MHz)
AUTO_FRAMES, 72, frames per pattern in auto mode (1 s at 800x600@72)
DB_W, 19, debounce counter width; must hold DEBOUNCE_CYCLES-1
FR_W, 7, frame counter width; must hold AUTO_FRAMES-1

Ports:
clk  input  1  pixel clock, rising edge
rst  input  1  reset, asynchronous, active-low
vsync  input  1  active-low vsync from the sync generator, clk domain
btn_next_n  input  1  raw "next pattern" key, active-low, asynchronous
btn_mode_n  input  1  raw "manual/auto toggle" key, active-low, asynchronous
type  output  2  pattern select to the VGA datapath (00 black, 01 red, 10 green, 11 blue)
auto_mode  output  1  0 = manual, 1 = auto
frame_tick  output  1  one-cycle pulse per detected frame start
type_changed  output  1  one-cycle pulse in the cycle type takes a new value

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-low. Reset applies immediately, including mid-frame or mid-debounce.
- Reset values: type=00, auto_mode=0, frame_tick=0, type_changed=0. Debounce and frame counters are 0. Synchronizer flops and stable button levels are 1 (released). The vsync history flop is 1. State is S_MAN.
- Frame start: fs = (vsync_d == 1 && vsync == 0), where vsync_d is vsync registered once. frame_tick is fs registered, i.e. it rises 1 cycle after the vsync falling edge.
- Buttons, each handled independently:
  - 2-flop synchronizer.
  - Debounce counter resets to 0 whenever the synchronized level equals the stable level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the level still differing, the stable level takes the new value and the counter clears.
  - A press event is a one-cycle pulse on the stable level's 1->0 transition. Releases generate no event.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- States: S_MAN, S_MAN_PEND, S_AUTO, S_AUTO_PEND. auto_mode = 1 in S_AUTO and S_AUTO_PEND.
- S_MAN:
  - next_press -> S_MAN_PEND.
  - next_press together with fs in the same cycle -> advance applied at this fs, stay in S_MAN.
- S_MAN_PEND:
  - fs -> advance, then S_MAN.
  - Further next presses are absorbed: at most one advance per frame.
- S_AUTO:
  - Frame counter increments on each fs.
  - On fs with count == AUTO_FRAMES-1 -> advance, count to 0.
  - next_press -> S_AUTO_PEND.
- S_AUTO_PEND:
  - fs -> advance, count to 0, then S_AUTO.
- Mode toggle: mode_press in any state toggles between the manual and auto groups.
  - Target state is S_MAN or S_AUTO; any pending request is dropped.
  - Frame counter clears. type is unchanged.
- Simultaneous events: mode_press has priority over next_press and fs in the same cycle; that cycle produces no advance.
- Advance: type <= type + 1, modulo 4 (11 -> 00 wrap). Registered one cycle after the fs cycle, i.e. aligned with frame_tick. type_changed pulses in that same cycle.
- Latency: from the raw key edge, a press event occurs after 2 + DEBOUNCE_CYCLES cycles (±1). type then changes at the first fs after the event.
- Arithmetic: all counters are unsigned and wrap-free by construction. The frame counter compares with ==, never overflows, and is held at 0 in the manual states.

Optional Feature:
SEQ_SKIP_BLACK_EN:
- Defined: in the auto states only, an advance from 11 goes to 01, skipping black. Manual stepping still visits 00. Entering auto while type=00 does not force a change; the next auto advance goes 00 -> 01.
- Undefined: full 00 -> 01 -> 10 -> 11 -> 00 cycle in both modes.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, AUTO_FRAMES=3, synthetic vsync with a 100-cycle period and 10 cycles low.)
- Reset sequence: assert rst=0 asynchronously mid-frame -> type=00, auto_mode=0, all pulses 0 in the same cycle; after release there is no activity until a key or fs occurs.
- Bounce rejection: btn_next_n low for 3 cycles then high, repeated -> no press event and type stays 00. Held low for 10 cycles -> exactly one advance to 01 at the next fs, with type_changed high for 1 cycle.
- Multiple presses: 3 debounced next presses within one frame -> type advances by exactly 1. Presses in 4 consecutive frames from type=11 -> 00, 01, 10, 11 (wrap verified).
- Auto mode: mode press -> auto_mode=1; type advances on every 3rd fs: 00 -> 01 after fs #3, then 10 after fs #6. A next press after fs #7 -> advance at fs #8 and the counter restarts.
- Simultaneous events: mode_press and fs in the same cycle while S_MAN_PEND -> no advance, auto_mode=1, pending dropped.
- SEQ_SKIP_BLACK_EN defined: auto from type=10 -> 11 -> 01, never 00; a manual next from 11 -> 00.
